// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with mid-bit sampling, glitch rejection and framing-error flag
module uart_rx #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_serial_data,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_rx_busy,
  output logic       o_rx_framing_err
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_d;
  logic          valid_d, err_d;
  logic          rx_meta, rx_s;

  // Two-flop synchroniser, reset to the idle (high) line level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx_serial_data;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      idx_q            <= '0;
      shift_q          <= '0;
      o_rx_byte        <= 8'h00;
      o_rx_valid       <= 1'b0;
      o_rx_framing_err <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      idx_q            <= idx_d;
      shift_q          <= shift_d;
      o_rx_byte        <= byte_d;
      o_rx_valid       <= valid_d;
      o_rx_framing_err <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = o_rx_byte;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        // Re-check the line half a bit in: a short low pulse is dropped silently
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_rx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized frame stimulus against a queue-based event model of uart_rx
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int LAT = 9 * CPB + CPB / 2 + 3;
  localparam int TOL = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid, rx_busy, rx_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         due;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] model_byte = 8'h00;
  logic       prev_pulse = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_rx_serial_data(rx),
    .o_rx_byte(rx_byte),
    .o_rx_valid(rx_valid),
    .o_rx_busy(rx_busy),
    .o_rx_framing_err(rx_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one 8N1 frame and records the single event it must produce
  task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int low_extra);
    ev_t ev;
    ev.is_err = !stop_ok;
    ev.data   = data;
    ev.due    = cyc + LAT;
    evq.push_back(ev);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      tick(CPB);
      if (i == 3) check(rx_busy == 1'b1, "busy_mid_frame", int'(rx_busy), 1);
    end
    rx = stop_ok;
    tick(CPB);
    if (!stop_ok) tick(low_extra);
    rx = 1'b1;
  endtask

  // Compare process: every pulse must match the head of the expected-event queue
  always @(negedge clk) begin
    if (!rst_n) begin
      check(rx_valid == 1'b0 && rx_err == 1'b0, "reset_pulses", int'({rx_valid, rx_err}), 0);
      check(rx_busy == 1'b0, "reset_busy", int'(rx_busy), 0);
      check(rx_byte == 8'h00, "reset_byte", int'(rx_byte), 0);
      model_byte = 8'h00;
      prev_pulse = 1'b0;
    end else begin
      check(!(rx_valid && rx_err), "valid_and_err", int'({rx_valid, rx_err}), 0);
      check(!(prev_pulse && (rx_valid || rx_err)), "pulse_width", 2, 1);
      prev_pulse = rx_valid || rx_err;
      if (rx_valid || rx_err) begin
        if (evq.size() == 0) begin
          check(1'b0, "unexpected_pulse", int'({rx_valid, rx_err}), 0);
        end else begin
          ev_t ev;
          ev = evq.pop_front();
          check(ev.is_err == rx_err, "event_kind", int'(rx_err), int'(ev.is_err));
          check(cyc >= ev.due - TOL && cyc <= ev.due + TOL, "event_time", cyc, ev.due);
          if (!ev.is_err) begin
            check(rx_byte == ev.data, "rx_data", int'(rx_byte), int'(ev.data));
            model_byte = ev.data;
          end
        end
      end else if (evq.size() > 0 && cyc > evq[0].due + TOL) begin
        check(1'b0, "missed_event", 0, evq[0].due);
        void'(evq.pop_front());
      end
      check(rx_byte == model_byte, "byte_hold", int'(rx_byte), int'(model_byte));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(5);
    rst_n = 1'b1;
    tick(500);
    check(rx_busy == 1'b0, "idle_busy", int'(rx_busy), 0);
    check(rx_byte == 8'h00, "idle_byte", int'(rx_byte), 0);

    send_frame(8'hD4, 1'b1, 0);
    tick(2 * CPB);
    check(rx_byte == 8'hD4, "single_D4", int'(rx_byte), 8'hD4);
    check(rx_busy == 1'b0, "busy_after_frame", int'(rx_busy), 0);

    // Back-to-back repeats, then a data change, with no idle gap
    for (int i = 0; i < 3; i++) send_frame(8'hD4, 1'b1, 0);
    send_frame(8'h05, 1'b1, 0);
    tick(2 * CPB);
    check(rx_byte == 8'h05, "b2b_05", int'(rx_byte), 8'h05);

    send_frame(8'hA5, 1'b0, 3 * CPB);
    tick(2 * CPB);
    check(rx_byte == 8'h05, "ferr_hold", int'(rx_byte), 8'h05);
    send_frame(8'h3C, 1'b1, 0);
    tick(2 * CPB);
    check(rx_byte == 8'h3C, "after_ferr_3C", int'(rx_byte), 8'h3C);

    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2 * CPB);
    check(rx_busy == 1'b0, "glitch_idle", int'(rx_busy), 0);
    send_frame(8'h81, 1'b1, 0);
    tick(2 * CPB);
    check(rx_byte == 8'h81, "after_glitch_81", int'(rx_byte), 8'h81);

    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB);
    rst_n = 1'b0;
    tick(5);
    rst_n = 1'b1;
    tick(6 * CPB);
    check(rx_byte == 8'h00, "after_reset_byte", int'(rx_byte), 0);
    send_frame(8'h42, 1'b1, 0);
    tick(2 * CPB);
    check(rx_byte == 8'h42, "after_reset_42", int'(rx_byte), 8'h42);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      bit         ok;
      d  = 8'($urandom);
      ok = ($urandom_range(99) >= 15);
      send_frame(d, ok, ok ? 0 : int'($urandom_range(40)));
      if (!ok) tick(CPB + int'($urandom_range(CPB)));
      else if ($urandom_range(9) < 3) tick(0);
      else tick(int'($urandom_range(3 * CPB)));
    end

    tick(3 * CPB);
    check(evq.size() == 0, "queue_drained", evq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
